// File: rtl/ciphertext_receiver.sv
// ciphertext_receiver
//   Rebuilds one MSG_SIZE-bit ciphertext frame from a serial bit stream and
//   decrypts it with a repeating KEY_SIZE-bit XOR key. Decryption runs one
//   key-width chunk per cycle. The plaintext is then offered on a valid/ready
//   handshake.
//
// Ports
//   clk, rst       clock, synchronous active-high reset (rst wins over ena)
//   ena            global enable; when low every register holds
//   iData_in       serial ciphertext bit, MSB first
//   iData_flag     high while frame bits are being driven
//   iKey           XOR key, latched on the first bit of a frame
//   oPlaintext     decrypted frame, updated only when decryption completes
//   oValid         oPlaintext is valid (held until iReady)
//   iReady         consumer accepts oPlaintext (only looked at in HOLD)
//   oBit_counter   bits captured in the current frame
//   oBusy          receiver is not idle
//   oFrame_error   one-cycle pulse on a framing fault
//   oErr_code      last fault: 00 none, 01 short, 10 overrun, 11 dropped
module ciphertext_receiver #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        iData_in,
    input  logic                        iData_flag,
    input  logic [KEY_SIZE-1:0]         iKey,
    output logic [MSG_SIZE-1:0]         oPlaintext,
    output logic                        oValid,
    input  logic                        iReady,
    output logic [$clog2(MSG_SIZE):0]   oBit_counter,
    output logic                        oBusy,
    output logic                        oFrame_error,
    output logic [1:0]                  oErr_code
);

    localparam int CNT_W  = $clog2(MSG_SIZE) + 1;
    localparam int NCHUNK = MSG_SIZE / KEY_SIZE;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DECRYPT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [MSG_SIZE-1:0] shift_q, shift_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MSG_SIZE-1:0] pt_q, pt_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ferr_q, ferr_d;
    logic [1:0]          err_q, err_d;
    logic                flag_prev_q, flag_prev_d;
    logic                block_q, block_d;
    logic                flag_rise;

    assign flag_rise = iData_flag & ~flag_prev_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        key_d       = key_q;
        idx_d       = idx_q;
        pt_d        = pt_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        ferr_d      = 1'b0;
        err_d       = err_q;
        flag_prev_d = iData_flag;
        // A flag assertion that is seen while busy (overrun tail or dropped
        // frame) must be released before IDLE will start a new frame. This
        // also keeps a flag that is already high when HOLD is left from
        // starting a frame.
        block_d     = iData_flag & (block_q | (state_q == DECRYPT) | (state_q == HOLD));

        unique case (state_q)
            IDLE: begin
                if (iData_flag && !block_q) begin
                    shift_d = {{(MSG_SIZE-1){1'b0}}, iData_in};
                    cnt_d   = CNT_W'(1);
                    key_d   = iKey;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (iData_flag) begin
                    shift_d = {shift_q[MSG_SIZE-2:0], iData_in};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MSG_SIZE - 1)) begin
                        idx_d   = '0;
                        state_d = DECRYPT;
                    end
                end else begin
                    ferr_d  = 1'b1;
                    err_d   = 2'b01;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = IDLE;
                end
            end
            DECRYPT: begin
                // Chunks are decrypted in place; the result is copied to the
                // output only on the last chunk so partial data never shows.
                shift_d[idx_q*KEY_SIZE +: KEY_SIZE] = shift_q[idx_q*KEY_SIZE +: KEY_SIZE] ^ key_q;
                if (idx_q == '0 && iData_flag) begin
                    ferr_d = 1'b1;
                    err_d  = 2'b10;
                end else if (flag_rise) begin
                    ferr_d = 1'b1;
                    err_d  = 2'b11;
                end
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    pt_d    = shift_d;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (flag_rise) begin
                    ferr_d = 1'b1;
                    err_d  = 2'b11;
                end
                if (iReady) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            key_q       <= '0;
            idx_q       <= '0;
            pt_q        <= '0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            ferr_q      <= 1'b0;
            err_q       <= 2'b00;
            flag_prev_q <= 1'b0;
            block_q     <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            key_q       <= key_d;
            idx_q       <= idx_d;
            pt_q        <= pt_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            ferr_q      <= ferr_d;
            err_q       <= err_d;
            flag_prev_q <= flag_prev_d;
            block_q     <= block_d;
        end
    end

    assign oPlaintext   = pt_q;
    assign oValid       = valid_q;
    assign oBit_counter = cnt_q;
    assign oBusy        = (state_q != IDLE);
    assign oFrame_error = ferr_q;
    assign oErr_code    = err_q;

endmodule

// File: tb/tb_ciphertext_receiver.sv
// Directed bench for ciphertext_receiver (defaults MSG_SIZE=64, KEY_SIZE=8).
module tb_ciphertext_receiver;

    logic        clk = 1'b0;
    logic        rst, ena, iData_in, iData_flag, iReady;
    logic [7:0]  iKey;
    logic [63:0] oPlaintext;
    logic        oValid, oBusy, oFrame_error;
    logic [6:0]  oBit_counter;
    logic [1:0]  oErr_code;

    int passes = 0;
    int fails  = 0;
    int lat;
    logic [63:0] held;
    logic        stable;

    ciphertext_receiver #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .iData_in     (iData_in),
        .iData_flag   (iData_flag),
        .iKey         (iKey),
        .oPlaintext   (oPlaintext),
        .oValid       (oValid),
        .iReady       (iReady),
        .oBit_counter (oBit_counter),
        .oBusy        (oBusy),
        .oFrame_error (oFrame_error),
        .oErr_code    (oErr_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive bits [from, to) of d with the flag high; bits past 63 are ones.
    task automatic send(input logic [63:0] d, input int from, input int to);
        for (int i = from; i < to; i++) begin
            iData_flag = 1'b1;
            iData_in   = (i < 64) ? d[63-i] : 1'b1;
            tick();
        end
    endtask

    // Count edges until oValid, giving up after 20.
    task automatic wait_valid(output int n);
        n = 0;
        while (!oValid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; iData_in = 1'b0; iData_flag = 1'b0;
        iReady = 1'b0; iKey = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_pt",    oPlaintext,   64'h0);
        check("rst_valid", oValid,       0);
        check("rst_cnt",   oBit_counter, 0);
        check("rst_ferr",  oFrame_error, 0);
        check("rst_err",   oErr_code,    0);
        check("rst_busy",  oBusy,        0);

        // Nominal decrypt
        iKey = 8'hAC; iReady = 1'b1;
        send(64'h0123456789ABCDEF, 0, 64);
        iData_flag = 1'b0;
        check("nom_cnt64", oBit_counter, 64);
        check("nom_busy",  oBusy,        1);
        wait_valid(lat);
        check("nom_latency", lat, 8);
        check("nom_pt",    oPlaintext, 64'hAD8FE9CB25076143);
        tick();
        check("nom_valid_low", oValid,       0);
        check("nom_cnt0",      oBit_counter, 0);
        check("nom_idle",      oBusy,        0);

        // Zero key passthrough
        iKey = 8'h00;
        send(64'hFFFF0000A5A5C3C3, 0, 64);
        iData_flag = 1'b0;
        wait_valid(lat);
        check("zero_pt", oPlaintext, 64'hFFFF0000A5A5C3C3);
        tick();

        // Backpressure
        iKey = 8'h3C; iReady = 1'b0;
        send(64'hDEADBEEFCAFEF00D, 0, 64);
        iData_flag = 1'b0;
        wait_valid(lat);
        check("bp_pt", oPlaintext, 64'hE29182D3F6C2CC31);
        held = oPlaintext; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!oValid || oPlaintext !== held) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        iReady = 1'b1;
        tick();
        check("bp_valid_low", oValid, 0);
        check("bp_idle",      oBusy,  0);

        // Short frame
        iKey = 8'hAC;
        send(64'h0123456789ABCDEF, 0, 10);
        check("short_cnt10", oBit_counter, 10);
        iData_flag = 1'b0;
        tick();
        check("short_ferr", oFrame_error, 1);
        check("short_err",  oErr_code,    2'b01);
        check("short_cnt0", oBit_counter, 0);
        check("short_idle", oBusy,        0);
        tick();
        check("short_pulse_end", oFrame_error, 0);
        check("short_no_valid",  oValid,       0);
        send(64'h0123456789ABCDEF, 0, 64);
        iData_flag = 1'b0;
        wait_valid(lat);
        check("short_next_pt", oPlaintext, 64'hAD8FE9CB25076143);
        check("short_err_kept", oErr_code, 2'b01);
        tick();

        // Overrun: 66 bits, extra ones must not reach the frame
        iKey = 8'h01; iReady = 1'b0;
        send(64'h8000000000000001, 0, 65);
        check("ovr_ferr", oFrame_error, 1);
        check("ovr_err",  oErr_code,    2'b10);
        send(64'h8000000000000001, 65, 66);
        iData_flag = 1'b0;
        wait_valid(lat);
        check("ovr_pt", oPlaintext, 64'h8101010101010100);
        // Frame start while holding
        tick();
        iData_flag = 1'b1;
        tick();
        check("drop_ferr",  oFrame_error, 1);
        check("drop_err",   oErr_code,    2'b11);
        check("drop_pt",    oPlaintext,   64'h8101010101010100);
        check("drop_valid", oValid,       1);
        iData_flag = 1'b0;
        tick();
        iReady = 1'b1;
        tick();
        check("drop_accept", oValid, 0);

        // Reset mid-frame
        iKey = 8'h77;
        send(64'h0F0F0F0F0F0F0F0F, 0, 30);
        iData_flag = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_pt",   oPlaintext,   64'h0);
        check("mrst_cnt",  oBit_counter, 0);
        check("mrst_busy", oBusy,        0);
        check("mrst_err",  oErr_code,    2'b00);
        check("mrst_ferr", oFrame_error, 0);

        // Enable stall and mid-frame key change
        iKey = 8'h5A;
        send(64'h1122334455667788, 0, 1);
        iKey = 8'hFF;
        send(64'h1122334455667788, 1, 20);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iData_in = ~iData_in;
            tick();
        end
        check("ena_cnt_frozen", oBit_counter, 20);
        ena = 1'b1;
        send(64'h1122334455667788, 20, 64);
        iData_flag = 1'b0;
        wait_valid(lat);
        check("ena_pt", oPlaintext, 64'h4B78691E0F3C2DD2);
        tick();

        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule

// File: doc/ciphertext_receiver.md
Name: ciphertext_receiver

Overview:
- Downstream consumer of the ciphertext serializer's output pair: data bit plus framing flag.
- Re-assembles one MSG_SIZE-bit ciphertext frame from the serial stream.
- Decrypts the frame with the repeating KEY_SIZE-bit XOR key, one key-width chunk per cycle.
- Presents the plaintext on a valid/ready handshake.
- Used as the on-chip loopback checker and as the host-side receive model in simulation.

Parameters:
- MSG_SIZE, 64: frame length in bits; must be a multiple of KEY_SIZE.
- KEY_SIZE, 8: XOR key width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; when low, all state and outputs hold.
- iData_in  in  1  serial ciphertext bit, MSB first.
- iData_flag  in  1  high while frame bits are being driven.
- iKey  in  KEY_SIZE  XOR key.
- oPlaintext  out  MSG_SIZE  decrypted frame.
- oValid  out  1  oPlaintext is valid.
- iReady  in  1  consumer accepts oPlaintext.
- oBit_counter  out  $clog2(MSG_SIZE)+1  bits captured in the current frame.
- oBusy  out  1  high in any state other than IDLE.
- oFrame_error  out  1  one-cycle pulse on a framing fault.
- oErr_code  out  2  last fault: 00 none, 01 short frame, 10 overrun, 11 frame dropped while busy.

Behaviour:
- All registers update on posedge clk.
- rst takes priority over ena.
- Reset values:
  - state = IDLE.
  - oPlaintext = 0, oValid = 0, oBit_counter = 0.
  - oFrame_error = 0, oErr_code = 00.
  - Internal shift register, key latch and chunk index = 0.
- When ena is low, nothing changes, including pulses: an oFrame_error pulse stays high until ena returns.
- FSM states: IDLE, SHIFT, DECRYPT, HOLD.
- IDLE:
  - If iData_flag = 1: shift in iData_in, set oBit_counter = 1, latch iKey, go to SHIFT.
  - The key is latched only at this point. Later changes to iKey do not affect the frame.
- SHIFT:
  - While iData_flag = 1: shift left (new bit into the LSB) and increment oBit_counter.
  - On the edge that captures bit number MSG_SIZE: go to DECRYPT with chunk index 0.
  - If iData_flag = 0 before MSG_SIZE bits are captured (short frame):
    - Pulse oFrame_error and set oErr_code = 01.
    - Clear oBit_counter and discard the frame.
    - Go to IDLE.
- DECRYPT (exactly MSG_SIZE/KEY_SIZE cycles):
  - Chunk j occupies plaintext bits [j*KEY_SIZE +: KEY_SIZE] and equals the same ciphertext slice XOR the latched key.
  - oPlaintext is updated only at the exit edge; it never shows partial results.
  - Exit: go to HOLD with oValid = 1.
  - Latency: oValid rises MSG_SIZE/KEY_SIZE edges after the last-bit edge (8 with defaults).
- Overrun:
  - If iData_flag is still high on the first DECRYPT edge: pulse oFrame_error and set oErr_code = 10.
  - The frame is still delivered.
  - Bits beyond MSG_SIZE are ignored.
  - A new frame is not accepted until iData_flag has been low for at least one cycle.
- HOLD:
  - oValid = 1 and oPlaintext stable until iReady = 1 on an edge.
  - On acceptance: oValid = 0, oBit_counter = 0, go to IDLE.
  - iReady is ignored in every other state.
- Frame start while busy:
  - A rising iData_flag (low to high) seen in DECRYPT or HOLD means the frame is dropped.
  - Pulse oFrame_error and set oErr_code = 11.
  - The pending plaintext is unaffected.
  - That flag assertion must go low before IDLE will accept a new frame.
- oErr_code holds until the next fault or rst. Successful frames do not clear it.
- Simultaneous events: in the cycle HOLD is left, an iData_flag already high does not start a frame. A rising edge is required.
- rst mid-frame (any state): immediate return to the reset values. The partial frame is lost and no error is reported.

Test Plan:
- Nominal decrypt: iKey = 0xAC, 64 bits of 0x0123456789ABCDEF MSB first, iReady = 1 → oValid after 8 cycles, oPlaintext = 0xAD8FE9CB25076143, oBit_counter 64 then 0.
- Zero key passthrough: iKey = 0x00, frame 0xFFFF0000A5A5C3C3 → oPlaintext = 0xFFFF0000A5A5C3C3.
- Backpressure: iReady = 0 for 20 cycles after oValid → oPlaintext stable and oValid held; iReady = 1 → oValid low next cycle, oBusy low.
- Short frame: flag high for 10 bits, then low → oFrame_error for 1 cycle, oErr_code = 01, no oValid; a following full frame decodes correctly.
- Overrun and busy drop:
  - Flag held 66 bits → oErr_code = 10, plaintext still delivered.
  - A new flag rising edge during HOLD → oErr_code = 11, held plaintext unchanged.
- Reset and enable:
  - rst pulse after 30 bits → all outputs at reset values.
  - ena low for 5 cycles mid-SHIFT → oBit_counter frozen, final plaintext still correct.
  - Key change mid-frame → latched key used.
